// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame deframer.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK,
        ST_EMIT
    } frame_state_t;

    localparam logic [7:0] SOF_BYTE = 8'hAA;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for one frame: synchronous write, asynchronous read, contents never reset.
module uart_frame_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 5
) (
    input  logic          clk,
    input  logic          wrEn_i,
    input  logic [AW-1:0] wrAddr_i,
    input  logic [7:0]    wrData_i,
    input  logic [AW-1:0] rdAddr_i,
    output logic [7:0]    rdData_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
    end

    assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/uart_frame_parser.sv
// Deframes AA/CMD/LEN/payload/CHK frames and replays the payload on a valid/ready stream.
// Define UART_FRAME_TIMEOUT_EN to abort partial frames after TIMEOUT_CYCLES idle cycles.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    localparam int unsigned LW            = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic [7:0]    out_cmd,
    output logic [LW-1:0] out_len,
    output logic [7:0]    out_data,
    output logic          out_valid,
    output logic          out_last,
    input  logic          out_ready,
    output logic          err_checksum,
    output logic          err_len,
    output logic          err_overrun,
    output logic          err_timeout,
    output logic          busy
);

    frame_state_t  state_q;
    logic [7:0]    cmd_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] wrIdx_q;
    logic [LW-1:0] rdIdx_q;
    logic [7:0]    xorAcc_q;
    logic          errChk_q;
    logic          errLen_q;
    logic          errOvr_q;
    logic [LW-1:0] lenLast;
    logic          bufWrEn;
    logic [7:0]    bufRdData;
    logic          emitting;

    if (TIMEOUT_CYCLES < 2) begin : gTimeoutCheck
        $error("uart_frame_parser: TIMEOUT_CYCLES must be at least 2");
    end

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int unsigned IDW = $clog2(TIMEOUT_CYCLES);
    // Idle count during cycle N+k after the last strobe is k-1, so firing at
    // TIMEOUT_CYCLES-2 raises the pulse exactly TIMEOUT_CYCLES cycles after it.
    localparam logic [IDW-1:0] TO_LIMIT = IDW'(TIMEOUT_CYCLES - 2);
    logic [IDW-1:0] idle_q;
    logic           errTo_q;
`endif

    assign lenLast = len_q - LW'(1);
    assign bufWrEn = (state_q == ST_PAYLOAD) && in_valid;

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (LW)
    ) uBuf (
        .clk      (clk),
        .wrEn_i   (bufWrEn),
        .wrAddr_i (wrIdx_q),
        .wrData_i (in_data),
        .rdAddr_i (rdIdx_q),
        .rdData_o (bufRdData)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_HUNT;
            cmd_q    <= '0;
            len_q    <= '0;
            wrIdx_q  <= '0;
            rdIdx_q  <= '0;
            xorAcc_q <= '0;
            errChk_q <= 1'b0;
            errLen_q <= 1'b0;
            errOvr_q <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
            idle_q   <= '0;
            errTo_q  <= 1'b0;
`endif
        end else begin
            errChk_q <= 1'b0;
            errLen_q <= 1'b0;
            errOvr_q <= 1'b0;
            case (state_q)
                ST_HUNT: begin
                    if (in_valid && in_data == SOF_BYTE) begin
                        state_q <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (in_valid) begin
                        cmd_q    <= in_data;
                        xorAcc_q <= in_data;
                        state_q  <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (in_valid) begin
                        if (in_data == 8'd0 || {24'd0, in_data} > MAX_LEN) begin
                            errLen_q <= 1'b1;
                            state_q  <= ST_HUNT;
                        end else begin
                            len_q    <= in_data[LW-1:0];
                            xorAcc_q <= xorAcc_q ^ in_data;
                            wrIdx_q  <= '0;
                            state_q  <= ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (in_valid) begin
                        xorAcc_q <= xorAcc_q ^ in_data;
                        if (wrIdx_q == lenLast) begin
                            wrIdx_q <= '0;
                            state_q <= ST_CHECK;
                        end else begin
                            wrIdx_q <= wrIdx_q + LW'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (in_valid) begin
                        if (in_data == xorAcc_q) begin
                            rdIdx_q <= '0;
                            state_q <= ST_EMIT;
                        end else begin
                            errChk_q <= 1'b1;
                            state_q  <= ST_HUNT;
                        end
                    end
                end
                ST_EMIT: begin
                    // Bytes arriving while replaying are lost, even on the final handshake.
                    if (in_valid) begin
                        errOvr_q <= 1'b1;
                    end
                    if (out_ready) begin
                        if (rdIdx_q == lenLast) begin
                            rdIdx_q <= '0;
                            state_q <= ST_HUNT;
                        end else begin
                            rdIdx_q <= rdIdx_q + LW'(1);
                        end
                    end
                end
                default: state_q <= ST_HUNT;
            endcase
`ifdef UART_FRAME_TIMEOUT_EN
            errTo_q <= 1'b0;
            if (state_q inside {ST_CMD, ST_LEN, ST_PAYLOAD, ST_CHECK}) begin
                if (in_valid) begin
                    idle_q <= '0;
                end else if (idle_q == TO_LIMIT) begin
                    idle_q  <= '0;
                    errTo_q <= 1'b1;
                    state_q <= ST_HUNT;
                end else begin
                    idle_q <= idle_q + IDW'(1);
                end
            end else begin
                idle_q <= '0;
            end
`endif
        end
    end

    assign emitting     = (state_q == ST_EMIT);
    assign out_valid    = emitting;
    assign out_cmd      = emitting ? cmd_q : 8'd0;
    assign out_len      = emitting ? len_q : '0;
    assign out_data     = emitting ? bufRdData : 8'd0;
    assign out_last     = emitting && (rdIdx_q == lenLast);
    assign err_checksum = errChk_q;
    assign err_len      = errLen_q;
    assign err_overrun  = errOvr_q;
    assign busy         = (state_q != ST_HUNT);

`ifdef UART_FRAME_TIMEOUT_EN
    assign err_timeout = errTo_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed self-checking bench for uart_frame_parser (MAX_LEN=16, TIMEOUT_CYCLES=20).
module tb_uart_frame_parser;

    localparam int unsigned MAX_LEN = 16;
    localparam int unsigned LW      = $clog2(MAX_LEN + 1);
`ifdef UART_FRAME_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_data = 8'd0;
    logic          in_valid = 1'b0;
    logic [7:0]    out_cmd;
    logic [LW-1:0] out_len;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_last;
    logic          out_ready = 1'b1;
    logic          err_checksum;
    logic          err_len;
    logic          err_overrun;
    logic          err_timeout;
    logic          busy;

    int errors = 0;
    int checks = 0;

    uart_frame_parser #(
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .out_cmd      (out_cmd),
        .out_len      (out_len),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .err_checksum (err_checksum),
        .err_len      (err_len),
        .err_overrun  (err_overrun),
        .err_timeout  (err_timeout),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge, so outputs are sampled mid-cycle.
    task automatic applyStimulus(input logic v, input logic [7:0] d);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
    endtask

    task automatic sendBytes(input logic [7:0] b [8], input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, b[i]);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, 32'(out_valid), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_data"}, 32'(out_data), 0);
        checkOutput({tag, "_cmd"}, 32'(out_cmd), 0);
        checkOutput({tag, "_len"}, 32'(out_len), 0);
        checkOutput({tag, "_last"}, 32'(out_last), 0);
        checkOutput({tag, "_errs"},
                    32'({err_checksum, err_len, err_overrun, err_timeout}), 0);
    endtask

    initial begin
        $display("[TB] start");
        repeat (3) applyStimulus(1'b0, 8'h00);
        checkAllZero("reset");
        rst = 1'b0;

        // Good frame, full-rate consumer
        sendBytes('{8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h13, 8'h00}, 7);
        applyStimulus(1'b0, 8'h00);
        checkOutput("good_valid", 32'(out_valid), 1);
        checkOutput("good_cmd", 32'(out_cmd), 32'h10);
        checkOutput("good_len", 32'(out_len), 3);
        checkOutput("good_d0", 32'(out_data), 32'h01);
        checkOutput("good_last0", 32'(out_last), 0);
        applyStimulus(1'b0, 8'h00);
        checkOutput("good_d1", 32'(out_data), 32'h02);
        checkOutput("good_last1", 32'(out_last), 0);
        applyStimulus(1'b0, 8'h00);
        checkOutput("good_d2", 32'(out_data), 32'h03);
        checkOutput("good_last2", 32'(out_last), 1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("good_done_busy", 32'(busy), 0);
        checkOutput("good_done_valid", 32'(out_valid), 0);

        // Bad checksum, then a one-byte good frame (chk 22^01^5A = 79)
        sendBytes('{8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h14, 8'h00}, 7);
        applyStimulus(1'b0, 8'h00);
        checkOutput("chk_pulse", 32'(err_checksum), 1);
        checkOutput("chk_novalid", 32'(out_valid), 0);
        checkOutput("chk_busy", 32'(busy), 0);
        applyStimulus(1'b0, 8'h00);
        checkOutput("chk_pulse_end", 32'(err_checksum), 0);
        sendBytes('{8'hAA, 8'h22, 8'h01, 8'h5A, 8'h79, 8'h00, 8'h00, 8'h00}, 5);
        applyStimulus(1'b0, 8'h00);
        checkOutput("after_chk_valid", 32'(out_valid), 1);
        checkOutput("after_chk_cmd", 32'(out_cmd), 32'h22);
        checkOutput("after_chk_data", 32'(out_data), 32'h5A);
        checkOutput("after_chk_last", 32'(out_last), 1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("after_chk_busy", 32'(busy), 0);

        // Garbage then zero length, then length 17
        applyStimulus(1'b1, 8'h55);
        applyStimulus(1'b1, 8'h66);
        applyStimulus(1'b1, 8'hAA);
        checkOutput("garbage_busy", 32'(busy), 0);
        sendBytes('{8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2);
        applyStimulus(1'b0, 8'h00);
        checkOutput("len0_pulse", 32'(err_len), 1);
        checkOutput("len0_busy", 32'(busy), 0);
        sendBytes('{8'hAA, 8'h20, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 3);
        applyStimulus(1'b0, 8'h00);
        checkOutput("len17_pulse", 32'(err_len), 1);
        checkOutput("len17_busy", 32'(busy), 0);
        applyStimulus(1'b0, 8'h00);
        checkOutput("len17_pulse_end", 32'(err_len), 0);

        // Backpressure for five cycles with an overrun byte in the middle
        out_ready = 1'b0;
        sendBytes('{8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h13, 8'h00}, 7);
        applyStimulus(1'b0, 8'h00);
        checkOutput("bp_c1_data", 32'(out_data), 32'h01);
        applyStimulus(1'b1, 8'h77);
        checkOutput("bp_c2_data", 32'(out_data), 32'h01);
        applyStimulus(1'b0, 8'h00);
        checkOutput("bp_ovr_pulse", 32'(err_overrun), 1);
        checkOutput("bp_c3_data", 32'(out_data), 32'h01);
        checkOutput("bp_c3_valid", 32'(out_valid), 1);
        applyStimulus(1'b0, 8'h00);
        checkOutput("bp_ovr_end", 32'(err_overrun), 0);
        checkOutput("bp_c4_data", 32'(out_data), 32'h01);
        applyStimulus(1'b0, 8'h00);
        checkOutput("bp_c5_data", 32'(out_data), 32'h01);
        checkOutput("bp_c5_last", 32'(out_last), 0);
        out_ready = 1'b1;
        applyStimulus(1'b0, 8'h00);
        checkOutput("bp_d1", 32'(out_data), 32'h02);
        applyStimulus(1'b0, 8'h00);
        checkOutput("bp_d2", 32'(out_data), 32'h03);
        checkOutput("bp_last", 32'(out_last), 1);

        // SOF arriving on the final handshake is an overrun, not a new frame
        applyStimulus(1'b0, 8'h00);
        sendBytes('{8'hAA, 8'h30, 8'h01, 8'h44, 8'h75, 8'h00, 8'h00, 8'h00}, 5);
        applyStimulus(1'b1, 8'hAA);
        checkOutput("final_valid", 32'(out_valid), 1);
        checkOutput("final_data", 32'(out_data), 32'h44);
        applyStimulus(1'b0, 8'h00);
        checkOutput("final_ovr", 32'(err_overrun), 1);
        checkOutput("final_busy", 32'(busy), 0);

        // Stalled partial frame: times out only when the feature is built
        sendBytes('{8'hAA, 8'h10, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
        for (int k = 1; k <= 25; k++) begin
            applyStimulus(1'b0, 8'h00);
            checkOutput($sformatf("to_err_k%0d", k), 32'(err_timeout),
                        32'(TO_EN && k == 20));
            checkOutput($sformatf("to_busy_k%0d", k), 32'(busy),
                        32'(!(TO_EN && k >= 20)));
        end

        // Reset in the middle of a payload, then a fresh frame
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00);
        rst = 1'b0;
        sendBytes('{8'hAA, 8'h10, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00);
        checkAllZero("midrst");
        rst = 1'b0;
        sendBytes('{8'hAA, 8'h10, 8'h03, 8'h01, 8'h02, 8'h03, 8'h13, 8'h00}, 7);
        applyStimulus(1'b0, 8'h00);
        checkOutput("post_rst_cmd", 32'(out_cmd), 32'h10);
        checkOutput("post_rst_d0", 32'(out_data), 32'h01);
        applyStimulus(1'b0, 8'h00);
        applyStimulus(1'b0, 8'h00);
        checkOutput("post_rst_d2", 32'(out_data), 32'h03);
        checkOutput("post_rst_last", 32'(out_last), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
